// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift-register sequencing controller.
// SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity bit to each word.
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  function automatic int sr_len(input int width);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_div.sv
// Shift-rate divider: one-cycle tick every DIV enabled clocks.
// Cleared on accept/abort so each word starts a fresh period.
module shift_rate_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serializes a word MSB-first into a shift register, then captures it.
// SHIFT_SEQ_CTRL_PARITY_EN adds a parity pulse and ParErrOut.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int DIV    = 1,
  localparam int SR_LEN = sr_len(WIDTH)
) (
  input  logic              ClkIn,
  input  logic              ClrIn,
  input  logic [WIDTH-1:0]  DataIn,
  input  logic              LoadReq,
  output logic              ReadyOut,
  input  logic              AbortIn,
  output logic              SerOut,
  output logic              ShiftEnaOut,
  input  logic [SR_LEN-1:0] ParIn,
  output logic [WIDTH-1:0]  ParOut,
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  output logic              ParErrOut,
`endif
  output logic              DoneOut,
  output logic              BusyOut
);

  localparam int BW = $clog2(SR_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SR_LEN - 1);

  state_e            state_q, state_d;
  logic [SR_LEN-1:0] hold_q, hold_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              ser_q, ser_d;
  logic              sena_q, sena_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  par_q, par_d;
  logic              perr_q, perr_d;
  logic [SR_LEN-1:0] load_word;
  logic              accept;
  logic              abort_seq;
  logic              tick;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  assign load_word = {DataIn, ^DataIn};
  assign ParErrOut = perr_q;
`else
  assign load_word = DataIn;
`endif

  assign accept = (state_q == IDLE) && LoadReq && !AbortIn;
  assign abort_seq = AbortIn &&
    ((state_q == SHIFT) || (state_q == SETTLE));

  shift_rate_div #(
    .DIV(DIV)
  ) u_div (
    .clk (ClkIn),
    .rst (ClrIn),
    .clr (accept || abort_seq),
    .en  (state_q == SHIFT),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    sena_d  = 1'b0;
    done_d  = 1'b0;
    par_d   = par_q;
    perr_d  = perr_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (accept) begin
          hold_d  = load_word;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      state_q == SHIFT: begin
        if (AbortIn) begin
          state_d = IDLE;
        end else if (tick) begin
          sena_d = 1'b1;
          ser_d  = hold_q[SR_LEN-1];
          hold_d = hold_q << 1;
          bit_d  = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = SETTLE;
        end
      end
      state_q == SETTLE: begin
        state_d = AbortIn ? IDLE : CAPTURE;
      end
      state_q == CAPTURE: begin
        par_d   = ParIn[WIDTH-1:0];
        perr_d  = ^ParIn;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge ClkIn or posedge ClrIn) begin
    if (ClrIn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
      sena_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      sena_q  <= sena_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
    end
  end

  assign ReadyOut    = ready_q;
  assign SerOut      = ser_q;
  assign ShiftEnaOut = sena_q;
  assign DoneOut     = done_q;
  assign BusyOut     = busy_q;
  assign ParOut      = par_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift register.
// Build with SHIFT_SEQ_CTRL_PARITY_EN to exercise the parity path.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int SRL = 6;
`else
  localparam int SRL = 5;
`endif

  logic           ClkIn = 1'b0;
  logic           ClrIn = 1'b1;
  logic [4:0]     DataIn = '0;
  logic           ld1 = 1'b0;
  logic           ld4 = 1'b0;
  logic           abort = 1'b0;
  logic           sel = 1'b0;
  logic           flip = 1'b0;

  logic           rdy1, ser1, sena1, done1, busy1;
  logic           rdy4, ser4, sena4, done4, busy4;
  logic [4:0]     par1, par4;
  logic [SRL-1:0] sr1 = '0;
  logic [SRL-1:0] sr4 = '0;
  logic [SRL-1:0] pin1, pin4;

  int pass_cnt = 0;
  int total = 0;

  logic [63:0] sena_v, done_v, ready_v, busy_v, ser_w;

  always #5 ClkIn = ~ClkIn;

  assign pin1 = sr1 ^ {{(SRL-1){1'b0}}, flip};
  assign pin4 = sr4;

  always_ff @(posedge ClkIn or posedge ClrIn) begin
    if (ClrIn) begin
      sr1 <= '0;
      sr4 <= '0;
    end else begin
      if (sena1) sr1 <= {sr1[SRL-2:0], ser1};
      if (sena4) sr4 <= {sr4[SRL-2:0], ser4};
    end
  end

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic perr1, perr4, perr_at_done;
`endif

  shift_seq_ctrl #(.WIDTH(5), .DIV(1)) u1 (
    .ClkIn      (ClkIn),
    .ClrIn      (ClrIn),
    .DataIn     (DataIn),
    .LoadReq    (ld1),
    .ReadyOut   (rdy1),
    .AbortIn    (abort),
    .SerOut     (ser1),
    .ShiftEnaOut(sena1),
    .ParIn      (pin1),
    .ParOut     (par1),
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    .ParErrOut  (perr1),
`endif
    .DoneOut    (done1),
    .BusyOut    (busy1)
  );

  shift_seq_ctrl #(.WIDTH(5), .DIV(4)) u4 (
    .ClkIn      (ClkIn),
    .ClrIn      (ClrIn),
    .DataIn     (DataIn),
    .LoadReq    (ld4),
    .ReadyOut   (rdy4),
    .AbortIn    (abort),
    .SerOut     (ser4),
    .ShiftEnaOut(sena4),
    .ParIn      (pin4),
    .ParOut     (par4),
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    .ParErrOut  (perr4),
`endif
    .DoneOut    (done4),
    .BusyOut    (busy4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic load(input logic s, input logic [4:0] d,
                      input bit keep);
    sel = s;
    DataIn = d;
    if (s) ld4 = 1'b1;
    else   ld1 = 1'b1;
    @(posedge ClkIn); #1;
    if (!keep) begin
      ld1 = 1'b0;
      ld4 = 1'b0;
      DataIn = '0;
    end
  endtask

  task automatic trace(input int n, input int drop_at,
                       input int ab_on, input int ab_off);
    logic se, sr, dn, rd, bz;
    sena_v = '0; done_v = '0; ready_v = '0;
    busy_v = '0; ser_w = '0;
    for (int c = 0; c < n; c++) begin
      se = sel ? sena4 : sena1;
      sr = sel ? ser4  : ser1;
      dn = sel ? done4 : done1;
      rd = sel ? rdy4  : rdy1;
      bz = sel ? busy4 : busy1;
      sena_v[c] = se;
      done_v[c] = dn;
      ready_v[c] = rd;
      busy_v[c] = bz;
      if (se) ser_w = {ser_w[62:0], sr};
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      if (dn) perr_at_done = perr1;
`endif
      if (c == drop_at) begin
        ld1 = 1'b0;
        ld4 = 1'b0;
      end
      if (c == ab_on)  abort = 1'b1;
      if (c == ab_off) abort = 1'b0;
      @(posedge ClkIn); #1;
    end
  endtask

  initial begin
    #12;
    check("rst_ready", 64'(rdy1), 64'd1);
    check("rst_busy",  64'(busy1), 64'd0);
    check("rst_sena",  64'(sena1), 64'd0);
    check("rst_ser",   64'(ser1), 64'd0);
    check("rst_done",  64'(done1), 64'd0);
    check("rst_par",   64'(par1), 64'd0);
    check("rst_ready4", 64'(rdy4), 64'd1);
    ClrIn = 1'b0;
    @(posedge ClkIn); #1;

`ifndef SHIFT_SEQ_CTRL_PARITY_EN
    load(1'b0, 5'h1C, 1'b0);
    check("t1_ready0", 64'(rdy1), 64'd0);
    trace(12, -1, -1, -1);
    check("t1_sena",  sena_v, 64'h3E);
    check("t1_done",  done_v, 64'h80);
    check("t1_busy",  busy_v, 64'h7F);
    check("t1_ser",   ser_w,  64'h1C);
    check("t1_sr",    64'(sr1), 64'h1C);
    check("t1_par",   64'(par1), 64'h1C);

    load(1'b1, 5'h15, 1'b0);
    trace(26, -1, -1, -1);
    check("t2_sena", sena_v, 64'h111110);
    check("t2_done", done_v, 64'h400000);
    check("t2_ser",  ser_w,  64'h15);
    check("t2_par",  64'(par4), 64'h15);

    load(1'b0, 5'h1C, 1'b1);
    DataIn = 5'h03;
    trace(17, 8, -1, -1);
    check("t3_sena",  sena_v, 64'h3E3E);
    check("t3_done",  done_v, 64'h8080);
    check("t3_ready", ready_v, 64'h18080);
    check("t3_ser",   ser_w,  64'h383);
    check("t3_par",   64'(par1), 64'h03);

    sel = 1'b0;
    abort = 1'b1;
    ld1 = 1'b1;
    DataIn = 5'h11;
    @(posedge ClkIn); #1;
    check("ab_idle_ready", 64'(rdy1), 64'd1);
    check("ab_idle_busy",  64'(busy1), 64'd0);
    abort = 1'b0;
    ld1 = 1'b0;

    load(1'b0, 5'h1F, 1'b0);
    trace(10, -1, 3, 4);
    check("t4_sena",  sena_v, 64'h0E);
    check("t4_done",  done_v, 64'h0);
    check("t4_ready", ready_v, 64'h3F0);
    check("t4_par",   64'(par1), 64'h03);
    check("t4_sr",    64'(sr1), 64'h1F);

    load(1'b0, 5'h0A, 1'b0);
    trace(3, -1, -1, -1);
    #2 ClrIn = 1'b1;
    #1;
    check("t5_ready", 64'(rdy1), 64'd1);
    check("t5_busy",  64'(busy1), 64'd0);
    check("t5_sena",  64'(sena1), 64'd0);
    check("t5_par",   64'(par1), 64'd0);
    check("t5_sr",    64'(sr1), 64'd0);
    #2 ClrIn = 1'b0;
    load(1'b0, 5'h0A, 1'b0);
    trace(9, -1, -1, -1);
    check("t5_done", done_v, 64'h80);
    check("t5_ser",  ser_w,  64'h0A);
    check("t5_par2", 64'(par1), 64'h0A);
`else
    perr_at_done = 1'b1;
    load(1'b0, 5'h07, 1'b0);
    trace(10, -1, -1, -1);
    check("t6_sena", sena_v, 64'h7E);
    check("t6_done", done_v, 64'h100);
    check("t6_ser",  ser_w,  64'h0F);
    check("t6_par",  64'(par1), 64'h0F);
    check("t6_perr", 64'(perr_at_done), 64'd0);
    flip = 1'b1;
    perr_at_done = 1'b0;
    load(1'b0, 5'h07, 1'b0);
    trace(10, -1, -1, -1);
    check("t6_done2", done_v, 64'h100);
    check("t6_perr2", 64'(perr_at_done), 64'd1);
    check("t6_par2",  64'(par1), 64'h0E);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for the 5-bit serial shift register (DIn/ShiftEna/QOut_p datapath).
- Accepts a parallel word over a valid/ready handshake.
- Serializes it MSB-first onto the register's DIn, pulsing ShiftEna at a programmable rate.
- Once the register has settled, captures the register's parallel output and reports completion.
- Sits between a host/config block and the shift register; the shift register shares ClkIn and ClrIn with it.

Parameters:
WIDTH, 5, bits per word; equals the attached shift-register length; must be >= 2
DIV, 1, shift-rate divider: one ShiftEna pulse every DIV clocks; must be >= 1

Ports:
ClkIn  input  1  clock, rising edge
ClrIn  input  1  reset, asynchronous, active-high; same net as the shift register's ClrIn
DataIn  input  WIDTH  word to serialize
LoadReq  input  1  valid for DataIn
ReadyOut  output  1  ready; a load is accepted on a rising edge with LoadReq=1 and ReadyOut=1
AbortIn  input  1  cancel the sequence in progress
SerOut  output  1  drives the shift register's DIn
ShiftEnaOut  output  1  drives the shift register's ShiftEna
ParIn  input  SR_LEN  from the shift register's QOut_p (SR_LEN defined under Optional Feature)
ParOut  output  WIDTH  captured parallel word
DoneOut  output  1  one-cycle completion pulse
BusyOut  output  1  high in every state except IDLE

Behaviour:
Reset (ClrIn=1, asynchronous):
- State goes to IDLE.
- ReadyOut=1; SerOut, ShiftEnaOut, DoneOut, BusyOut = 0; ParOut = 0.
- Hold register, bit counter and divider counter all 0.

Outputs and counters:
- All outputs are registered.
- The divider counter is max(1,$clog2(DIV)) bits wide and counts 0..DIV-1, then wraps.
- The bit counter is $clog2(SR_LEN+1) bits wide.

States and transitions:
- IDLE: ReadyOut=1. On accept:
  - Latch DataIn into the hold register.
  - Clear both counters.
  - Go to SHIFT; ReadyOut=0 from the next cycle.
- SHIFT: the divider counter increments every clock.
  - When it reaches DIV-1: assert ShiftEnaOut=1 for exactly one cycle with SerOut = hold MSB.
  - In the same edge, shift the hold register left and increment the bit counter.
  - After the SR_LEN-th pulse is issued, go to SETTLE.
  - SerOut holds its last value between pulses.
- SETTLE: ShiftEnaOut=0 (one cycle, lets the shift register absorb the final bit). Go to CAPTURE.
- CAPTURE: ParOut <= ParIn[WIDTH-1:0]; DoneOut=1 for one cycle; go to IDLE.
- Back-to-back loads: ReadyOut=1 again in the cycle DoneOut is high, so the next accept can occur on the following edge.

Timing, with the accept edge = cycle 0:
- Pulses are high in cycles k*DIV for k=1..SR_LEN.
- DoneOut is high in cycle SR_LEN*DIV+2.
- Throughput is one word per SR_LEN*DIV+3 cycles.

Boundary conditions:
- LoadReq while busy: ignored; the requester holds DataIn and LoadReq until accepted.
- AbortIn=1 in SHIFT or SETTLE: next edge goes to IDLE with ShiftEnaOut=0, no DoneOut, ParOut unchanged. The shift-register contents are left partial (not cleared).
- AbortIn=1 in CAPTURE: ignored; the capture completes.
- AbortIn=1 together with LoadReq in IDLE: abort wins, the load is not accepted.
- ClrIn mid-sequence: immediate return to IDLE at reset values; the shift register clears too.
- DataIn changing after accept has no effect.

Optional Feature:
Macro: SHIFT_SEQ_CTRL_PARITY_EN
Defined:
- SR_LEN = WIDTH+1.
- After the WIDTH data bits, one extra pulse shifts the even-parity bit (XOR of the latched word).
- Added output ParErrOut (1 bit), valid with DoneOut: 1 if the XOR of all ParIn bits is nonzero, else 0. Reset value 0.
- The attached register must be WIDTH+1 deep.
Undefined:
- SR_LEN = WIDTH; no parity pulse; no ParErrOut port.

Decomposition:
- Shared package holds the state encoding constants (IDLE=0, SHIFT=1, SETTLE=2, CAPTURE=3, 2 bits) and the SR_LEN derivation.
- One sub-module is natural: shift_rate_div (DIV counter emitting a one-cycle tick; cleared on accept/abort).
- The FSM, hold register and bit counter stay in the top level.

Test Plan:
1. WIDTH=5, DIV=1, macro off; load 5'h1C at cycle 0 -> ShiftEnaOut high cycles 1-5 with SerOut 1,1,1,0,0; QOut_p=5'h1C; ParOut=5'h1C, DoneOut high only in cycle 7.
2. DIV=4, load 5'h15 -> pulses at cycles 4,8,12,16,20 with SerOut 1,0,1,0,1; DoneOut in cycle 22; ParOut=5'h15.
3. Back-to-back: LoadReq held high with 5'h1C then 5'h03 -> second accept in cycle 8, its DoneOut in cycle 15, ParOut=5'h03; no pulse gap beyond SETTLE/CAPTURE.
4. AbortIn at cycle 3 during 5'h1F load -> no pulse from cycle 4, no DoneOut, ReadyOut=1 in cycle 4, ParOut keeps its previous value.
5. ClrIn pulsed for 3 ns in cycle 2 -> all outputs 0, ReadyOut=1 asynchronously; a new load of 5'h0A then completes with ParOut=5'h0A.
6. Macro on: load 5'h07 -> six pulses, last SerOut=1 (parity); ParErrOut=0. Force ParIn bit0 flipped -> ParErrOut=1 with DoneOut.
